// File: rtl/lbist_controller.sv
// LBIST sequencer: drives pattern generator, scan enable and MISR gating, then checks the final signature.
// Outputs are decoded from the registered state or held in registers; start is sampled only in IDLE/DONE.
module lbist_controller #(
  parameter int              N_PATTERNS = 1024,
  parameter int              CHAIN_LEN  = 64,
  parameter int              SIG_W      = 32,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [SIG_W-1:0]                  signature,
  output logic                              tpg_en,
  output logic                              tpg_rst_n,
  output logic                              scan_en,
  output logic                              misr_en,
  output logic                              misr_rst,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [$clog2(N_PATTERNS+1)-1:0]   pattern_cnt
);

  localparam int CNT_W = $clog2(N_PATTERNS + 1);
  localparam int SH_W  = $clog2(CHAIN_LEN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [SH_W-1:0]   shift_cnt;
  logic [CNT_W-1:0]  pat_cnt;
  logic              pass_q;
  logic              shift_last;

  assign shift_last = (shift_cnt == SH_W'(CHAIN_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = INIT;
      INIT:    state_next = SHIFT;
      SHIFT:   if (shift_last) state_next = (pat_cnt < CNT_W'(N_PATTERNS)) ? CAPTURE : COMPARE;
      CAPTURE: state_next = SHIFT;
      COMPARE: state_next = DONE;
      DONE:    if (start) state_next = INIT;
      default: state_next = IDLE;
    endcase
  end

  // Clearing on entry to INIT means a rerun shows pattern_cnt=0 and pass=0 already in the INIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cnt <= '0;
      pat_cnt   <= '0;
      pass_q    <= 1'b0;
    end else if (state_next == INIT) begin
      shift_cnt <= '0;
      pat_cnt   <= '0;
      pass_q    <= 1'b0;
    end else begin
      if (state == SHIFT) shift_cnt <= shift_last ? '0 : shift_cnt + SH_W'(1);
      if (state == CAPTURE) pat_cnt <= pat_cnt + CNT_W'(1);
      if (state == COMPARE) pass_q <= (signature == GOLDEN_SIG);
    end
  end

  always_comb begin
    tpg_en    = 1'b0;
    tpg_rst_n = 1'b1;
    scan_en   = 1'b0;
    misr_en   = 1'b0;
    misr_rst  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      INIT: begin
        tpg_rst_n = 1'b0;
        misr_rst  = 1'b1;
        busy      = 1'b1;
      end
      SHIFT: begin
        tpg_en  = 1'b1;
        scan_en = 1'b1;
        misr_en = 1'b1;
        busy    = 1'b1;
      end
      CAPTURE: busy = 1'b1;
      COMPARE: busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign pass        = pass_q;
  assign pattern_cnt = pat_cnt;

endmodule
